instr_fetch: RTL and testbench

Program-counter and fetch stage of the MiniALU datapath. Drives the address into the combinational instruction ROM and captures the returned 28-bit instruction into a registered instruction output. It then hands the instruction, with a valid flag and its address, to decode/execute. It also absorbs pipeline stalls, applies branch/jump redirects from execute, and implements the NOP delay (operand = idle cycle count) in hardware.

---
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Program-counter and fetch stage of the MiniALU datapath.
// The PC addresses the combinational instruction ROM. The returned word is
// registered and handed to decode/execute together with its fetch address
// and a valid flag. The stage also handles three other things:
//   - stalls from execute: everything freezes;
//   - taken branch/jump redirects: one bubble, and any NOP delay is aborted;
//   - delay-NOPs: a NOP with a non-zero operand N inserts N idle cycles.
//
// Ports
//   Clock          in   sole clock, rising edge
//   Reset          in   asynchronous, active-high
//   iStall         in   execute busy; hold every register
//   iBranchTaken   in   execute resolved a taken BLE/JMP this cycle
//   iBranchTarget  in   redirect address, qualified by iBranchTaken
//   oAddress       out  ROM address (= PC register)
//   iInstruction   in   ROM data for oAddress, same cycle
//   oInstruction   out  registered instruction for decode
//   oPC            out  address oInstruction was fetched from
//   oValid         out  oInstruction is live this cycle
//   oDelayBusy     out  NOP delay in progress
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter int          ADDR_W     = 16,
    parameter int          INSTR_W    = 28,
    parameter logic [3:0]  NOP_OPCODE = 4'd0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iStall,
    input  logic                iBranchTaken,
    input  logic [ADDR_W-1:0]   iBranchTarget,
    output logic [ADDR_W-1:0]   oAddress,
    input  logic [INSTR_W-1:0]  iInstruction,
    output logic [INSTR_W-1:0]  oInstruction,
    output logic [ADDR_W-1:0]   oPC,
    output logic                oValid,
    output logic                oDelayBusy
);

    localparam int OPND_W = INSTR_W - 4;

    typedef enum logic {
        FETCH = 1'b0,
        DELAY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q,    pc_d;
    logic [INSTR_W-1:0]  ir_q,    ir_d;
    logic [ADDR_W-1:0]   pcq_q,   pcq_d;
    logic                valid_q, valid_d;
    logic [OPND_W-1:0]   dcnt_q,  dcnt_d;

    logic [3:0]          fetch_opcode;
    logic [OPND_W-1:0]   fetch_operand;

    assign fetch_opcode  = iInstruction[INSTR_W-1 -: 4];
    assign fetch_operand = iInstruction[OPND_W-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            pcq_q   <= '0;
            valid_q <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pcq_q   <= pcq_d;
            valid_q <= valid_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority: branch > stall > normal operation.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcq_d   = pcq_q;
        valid_d = valid_q;
        dcnt_d  = dcnt_q;

        if (iBranchTaken) begin
            // Redirect: flush the in-flight instruction and abort any delay.
            // IR/PCQ keep their stale contents; VALID=0 masks them.
            pc_d    = iBranchTarget;
            valid_d = 1'b0;
            dcnt_d  = '0;
            state_d = FETCH;
        end else if (!iStall) begin
            unique case (state_q)
                FETCH: begin
                    ir_d    = iInstruction;
                    pcq_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + ADDR_W'(1);
                    // The NOP is still issued; its operand then sets how
                    // many idle cycles follow it. Operand 0 is a plain NOP.
                    if (fetch_opcode == NOP_OPCODE && fetch_operand != '0) begin
                        dcnt_d  = fetch_operand;
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    // PC already points past the NOP, so it simply holds.
                    valid_d = 1'b0;
                    dcnt_d  = dcnt_q - OPND_W'(1);
                    if (dcnt_q == OPND_W'(1)) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
        // Stall without branch: every register holds (defaults above).
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign oAddress     = pc_q;
    assign oInstruction = ir_q;
    assign oPC          = pcq_q;
    assign oValid       = valid_q;
    assign oDelayBusy   = (state_q == DELAY);

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Testbench for instr_fetch. A 256-word ROM image (address bits [7:0]) feeds
// the DUT combinationally. The reference model works at the level of
// "next fetch address / last issued instruction / idle cycles still owed".
// It is updated on every rising edge and on asynchronous reset. A compare
// process checks all outputs on every falling edge. The directed scenarios
// add literal expectations, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [15:0] iBranchTarget = 16'h0000;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic [27:0] oInstruction;
    logic [15:0] oPC;
    logic        oValid;
    logic        oDelayBusy;

    logic [27:0] rom [0:255];

    assign iInstruction = rom[oAddress[7:0]];

    always #5 Clock = ~Clock;

    instr_fetch #(
        .ADDR_W     (16),
        .INSTR_W    (28),
        .NOP_OPCODE (4'd0)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .oInstruction  (oInstruction),
        .oPC           (oPC),
        .oValid        (oValid),
        .oDelayBusy    (oDelayBusy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [15:0] m_next;     // address the stage will fetch next
    logic [27:0] m_instr;    // last instruction handed to decode
    logic [15:0] m_pc;       // its address
    logic        m_valid;    // issued this cycle
    int          m_bubbles;  // idle cycles still owed to a delay-NOP

    always @(posedge Clock or posedge Reset) begin
        logic [27:0] w;
        if (Reset) begin
            m_next = 16'h0; m_instr = 28'h0; m_pc = 16'h0; m_valid = 1'b0; m_bubbles = 0;
        end else if (iBranchTaken) begin
            m_next = iBranchTarget; m_valid = 1'b0; m_bubbles = 0;
        end else if (iStall) begin
            // nothing moves
        end else if (m_bubbles > 0) begin
            m_valid = 1'b0;
            m_bubbles = m_bubbles - 1;
        end else begin
            w = rom[m_next[7:0]];
            m_instr = w;
            m_pc    = m_next;
            m_valid = 1'b1;
            m_next  = m_next + 16'h1;
            if (w[27:24] == 4'h0) m_bubbles = int'(w[23:0]);
        end
    end

    always @(negedge Clock) begin
        chk("addr",  {16'h0, oAddress},     {16'h0, m_next});
        chk("pc",    {16'h0, oPC},          {16'h0, m_pc});
        chk("instr", {4'h0, oInstruction},  {4'h0, m_instr});
        chk("valid", {31'h0, oValid},       {31'h0, m_valid});
        chk("busy",  {31'h0, oDelayBusy},   {31'h0, (m_bubbles > 0)});
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic adv(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Asserts reset between edges, checks outputs clear immediately, and
    // releases it on the falling edge. The next edge fetches ROM[0].
    task automatic do_reset();
        @(posedge Clock);
        #3 Reset = 1'b1;
        #1;
        chk("rst_addr",  {16'h0, oAddress}, 32'h0);
        chk("rst_pc",    {16'h0, oPC}, 32'h0);
        chk("rst_instr", {4'h0, oInstruction}, 32'h0);
        chk("rst_valid", {31'h0, oValid}, 32'h0);
        chk("rst_busy",  {31'h0, oDelayBusy}, 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        iStall = 1'b0;
        iBranchTaken = 1'b0;
    endtask

    // Bounded wait until the model shows address a issued.
    task automatic wait_pc(input logic [15:0] a);
        int n = 0;
        while (!(m_valid && m_pc == a) && n < 100) begin
            adv(1);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL wait_pc timeout actual=%h required=%h", oPC, a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bubbles;
        for (int i = 0; i < 256; i++) rom[i] = {4'(1 + (i % 15)), 24'(i * 7 + 3)};

        // --- reset state, then sequential free-run ---
        @(negedge Clock);
        chk("init_valid", {31'h0, oValid}, 32'h0);
        chk("init_addr",  {16'h0, oAddress}, 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            adv(1);
            chk("seq_pc",    {16'h0, oPC}, 32'(k));
            chk("seq_valid", {31'h0, oValid}, 32'h1);
            chk("seq_instr", {4'h0, oInstruction}, {4'h0, 4'(1 + k), 24'(k * 7 + 3)});
        end

        // --- NOP 3 at address 3, NOP 0 at address 5 ---
        rom[3] = 28'h000_0003;
        rom[5] = 28'h000_0000;
        do_reset();
        adv(4);
        chk("nop_pc",    {16'h0, oPC}, 32'h3);
        chk("nop_valid", {31'h0, oValid}, 32'h1);
        chk("nop_busy",  {31'h0, oDelayBusy}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            adv(1);
            chk("nop_bubble", {31'h0, oValid}, 32'h0);
        end
        adv(1);
        chk("after_nop_pc", {16'h0, oPC}, 32'h4);
        chk("after_nop_v",  {31'h0, oValid}, 32'h1);
        adv(1);
        chk("nop0_pc", {16'h0, oPC}, 32'h5);
        adv(1);
        chk("nop0_next_pc", {16'h0, oPC}, 32'h6);
        chk("nop0_next_v",  {31'h0, oValid}, 32'h1);

        // --- reset in the middle of a delay ---
        do_reset();
        adv(5);
        chk("middelay_busy", {31'h0, oDelayBusy}, 32'h1);
        do_reset();
        adv(1);
        chk("postrst_pc",   {16'h0, oPC}, 32'h0);
        chk("postrst_busy", {31'h0, oDelayBusy}, 32'h0);

        // --- branch to 2 while oPC=10 ---
        wait_pc(16'd10);
        iBranchTaken = 1'b1; iBranchTarget = 16'd2;
        adv(1);
        iBranchTaken = 1'b0;
        chk("br_bubble", {31'h0, oValid}, 32'h0);
        adv(1);
        chk("br_pc",    {16'h0, oPC}, 32'h2);
        chk("br_valid", {31'h0, oValid}, 32'h1);

        // --- branch aborting a NOP 4000 delay ---
        rom[3] = 28'h000_0FA0;
        do_reset();
        wait_pc(16'd3);
        adv(10);
        chk("long_busy", {31'h0, oDelayBusy}, 32'h1);
        iBranchTaken = 1'b1; iBranchTarget = 16'd2;
        adv(1);
        iBranchTaken = 1'b0;
        chk("abort_busy",  {31'h0, oDelayBusy}, 32'h0);
        chk("abort_valid", {31'h0, oValid}, 32'h0);
        adv(1);
        chk("abort_pc", {16'h0, oPC}, 32'h2);

        // --- 5-cycle stall at oPC=7 ---
        rom[3] = 28'h000_0003;
        do_reset();
        wait_pc(16'd7);
        iStall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            adv(1);
            if (i == 5) iStall = 1'b0;
            chk("stall_pc",    {16'h0, oPC}, 32'h7);
            chk("stall_valid", {31'h0, oValid}, 32'h1);
        end
        adv(1);
        chk("unstall_pc", {16'h0, oPC}, 32'h8);

        // --- stall inside a NOP 3 delay stretches it to 8 bubbles ---
        do_reset();
        wait_pc(16'd3);
        bubbles = 0;
        for (int i = 1; i <= 30; i++) begin
            adv(1);
            if (oValid && oPC == 16'd4) break;
            if (!oValid) bubbles++;
            iStall = (i <= 5);
        end
        iStall = 1'b0;
        chk("stall_delay_bubbles", 32'(bubbles), 32'd8);

        // --- stall and branch together: branch wins ---
        iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 16'h0020;
        adv(1);
        iStall = 1'b0; iBranchTaken = 1'b0;
        chk("sb_bubble", {31'h0, oValid}, 32'h0);
        adv(1);
        chk("sb_pc",    {16'h0, oPC}, 32'h20);
        chk("sb_valid", {31'h0, oValid}, 32'h1);

        // --- wrap from 0xFFFF ---
        iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
        adv(1);
        iBranchTaken = 1'b0;
        adv(1);
        chk("wrap_pc_hi", {16'h0, oPC}, 32'hFFFF);
        adv(1);
        chk("wrap_pc_lo", {16'h0, oPC}, 32'h0);
        chk("wrap_valid", {31'h0, oValid}, 32'h1);

        // --- randomized run ---
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 99) < 12)
                rom[i] = {4'h0, 24'($urandom_range(0, 5))};
            else
                rom[i] = {4'($urandom_range(1, 15)), 24'($urandom)};
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            adv(1);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                iStall        = ($urandom_range(0, 99) < 20);
                iBranchTaken  = ($urandom_range(0, 99) < 6);
                iBranchTarget = 16'($urandom_range(0, 65535));
            end
        end
        iStall = 1'b0; iBranchTaken = 1'b0;
        adv(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
